// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Ports
//   clk            system clock, all state on the rising edge
//   resetb         asynchronous active-low reset
//   io_addr[7:0]   IO byte address (only [7:2] decoded)
//   io_en          IO access valid this cycle
//   io_we          access is a write when io_en=1
//   io_data_write  write data
//   io_data_read   combinational read data (0 unless a read is in progress)
//   irq            TX-done interrupt (only with IO_UART_TX_IRQ_EN)
//   txd            serial line, idle high
//
// Register map (word addresses 0x00..0x0C)
//   0x00 TXDATA  W    push [7:0] into the FIFO
//   0x04 STATUS  R/W1C  [0] busy [1] full [2] empty [3] overflow [4+:CW] count
//   0x08 BAUDDIV R/W  [15:0] clocks per bit, values below 2 stored as 2
//   0x0C IRQCTL  R/W  [0] irq enable (only with IO_UART_TX_IRQ_EN)
//
// Build option: define IO_UART_TX_IRQ_EN to add IRQCTL and the irq output.
//
// state | meaning
// IDLE  | line high, waiting for a FIFO byte
// START | start bit (low) for one bit period
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high), then next byte or IDLE

module io_uart_tx #(
   parameter int          FIFO_DEPTH     = 4,
   parameter int          FIFO_DEPTH_LOG = 2,
   parameter logic [15:0] BAUD_DIV_RESET = 16'd868
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [7:0]  io_addr,
   input  logic        io_en,
   input  logic        io_we,
   input  logic [31:0] io_data_write,
   output logic [31:0] io_data_read,
`ifdef IO_UART_TX_IRQ_EN
   output logic        irq,
`endif
   output logic        txd
);

   localparam int            CW        = FIFO_DEPTH_LOG + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
   localparam logic [5:0]    A_TXDATA  = 6'h00;
   localparam logic [5:0]    A_STATUS  = 6'h01;
   localparam logic [5:0]    A_BAUDDIV = 6'h02;
   localparam logic [5:0]    A_IRQCTL  = 6'h03;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                    state, state_nxt;
   logic [7:0]                mem [FIFO_DEPTH];
   logic [FIFO_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0]             count;
   logic                      ovf;
   logic [15:0]               baud_div, div_cnt;
   logic [2:0]                bit_idx;
   logic [7:0]                shift;
   logic                      full, empty, wr, push, push_ok, pop, tick;
   logic                      ovf_set, ovf_clr;
   logic [5:0]                sel;
   logic [31:0]               status;
   logic                      unused_bits;

   assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

   assign sel     = io_addr[7:2];
   assign wr      = io_en && io_we;
   assign full    = (count == DEPTH_C);
   assign empty   = (count == '0);
   assign push    = wr && (sel == A_TXDATA);
   // A push into a full FIFO still lands when the transmitter pops the same edge.
   assign push_ok = push && (!full || pop);
   assign ovf_set = push && full && !pop;
   assign ovf_clr = wr && (sel == A_STATUS) && io_data_write[3];
   assign tick    = (div_cnt == 16'd0);

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      case (state)
         IDLE:  if (!empty) begin
                   pop       = 1'b1;
                   state_nxt = START;
                end
         START: if (tick) state_nxt = DATA;
         DATA:  if (tick && bit_idx == 3'd7) state_nxt = STOP;
         STOP:  if (tick) begin
                   if (!empty) begin
                      pop       = 1'b1;
                      state_nxt = START;
                   end else begin
                      state_nxt = IDLE;
                   end
                end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      txd = 1'b1;
      case (state)
         START:   txd = 1'b0;
         DATA:    txd = shift[0];
         default: txd = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= io_data_write[7:0];
   end

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state    <= IDLE;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         ovf      <= 1'b0;
         baud_div <= BAUD_DIV_RESET;
         div_cnt  <= '0;
         bit_idx  <= '0;
         shift    <= '0;
      end else begin
         state <= state_nxt;
         if (push_ok) wr_ptr <= wr_ptr + FIFO_DEPTH_LOG'(1);
         if (pop)     rd_ptr <= rd_ptr + FIFO_DEPTH_LOG'(1);
         case ({push_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
         if (ovf_set)      ovf <= 1'b1;
         else if (ovf_clr) ovf <= 1'b0;
         if (wr && sel == A_BAUDDIV)
            baud_div <= (io_data_write[15:0] < 16'd2) ? 16'd2 : io_data_write[15:0];
         // Divider reloads from baud_div only at bit boundaries, so a new
         // divisor never truncates the bit currently on the line.
         if (pop) begin
            shift   <= mem[rd_ptr];
            div_cnt <= baud_div - 16'd1;
            bit_idx <= '0;
         end else if (state_nxt == IDLE) begin
            div_cnt <= '0;
         end else if (tick) begin
            div_cnt <= baud_div - 16'd1;
            if (state == DATA) begin
               shift   <= shift >> 1;
               bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            div_cnt <= div_cnt - 16'd1;
         end
      end
   end

`ifdef IO_UART_TX_IRQ_EN
   logic irq_ctl;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         irq_ctl <= 1'b0;
         irq     <= 1'b0;
      end else begin
         if (wr && sel == A_IRQCTL) irq_ctl <= io_data_write[0];
         irq <= irq_ctl && empty && (state == IDLE);
      end
   end
`endif

   always_comb begin
      status          = '0;
      status[0]       = (state != IDLE);
      status[1]       = full;
      status[2]       = empty;
      status[3]       = ovf;
      status[4 +: CW] = count;
   end

   always_comb begin
      io_data_read = '0;
      if (io_en && !io_we) begin
         case (sel)
            A_STATUS:  io_data_read = status;
            A_BAUDDIV: io_data_read = {16'd0, baud_div};
`ifdef IO_UART_TX_IRQ_EN
            A_IRQCTL:  io_data_read = {31'd0, irq_ctl};
`endif
            default:   io_data_read = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// Bench for io_uart_tx: directed steps plus randomized bursts. The expected
// line waveform is computed arithmetically from the list of accepted bytes
// (10 bit periods per frame, frames back to back).

module tb_io_uart_tx;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] BAUD_RST = 32'd868;

   logic        clk = 1'b0;
   logic        resetb;
   logic [7:0]  io_addr;
   logic        io_en;
   logic        io_we;
   logic [31:0] io_data_write;
   logic [31:0] io_data_read;
   logic        txd;
`ifdef IO_UART_TX_IRQ_EN
   logic        irq;
`endif

   always #5 clk = ~clk;

   io_uart_tx dut (
      .clk           (clk),
      .resetb        (resetb),
      .io_addr       (io_addr),
      .io_en         (io_en),
      .io_we         (io_we),
      .io_data_write (io_data_write),
      .io_data_read  (io_data_read),
`ifdef IO_UART_TX_IRQ_EN
      .irq           (irq),
`endif
      .txd           (txd)
   );

   int         n_cmp  = 0;
   int         n_fail = 0;
   logic [7:0] frames[$];
   logic [7:0] burst[6];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] addr, input logic [31:0] data);
      io_addr       = addr;
      io_data_write = data;
      io_en         = 1'b1;
      io_we         = 1'b1;
      @(posedge clk);
      #1;
      io_en = 1'b0;
      io_we = 1'b0;
   endtask

   task automatic chk_rd(input string tag, input logic [7:0] addr, input logic [31:0] exp);
      io_addr = addr;
      io_en   = 1'b1;
      io_we   = 1'b0;
      #1;
      chk(tag, io_data_read, exp);
      io_en = 1'b0;
   endtask

   function automatic logic [31:0] exp_status(input int busy, input int full, input int empty,
                                               input int ovf, input int cnt);
      return 32'(busy) | (32'(full) << 1) | (32'(empty) << 2) | (32'(ovf) << 3) | (32'(cnt) << 4);
   endfunction

   // Line level t cycles after the first frame started, for frames[] sent back to back.
   function automatic logic exp_txd(input int t, input int b);
      int         f, k;
      logic [7:0] d;
      if (t < 0) return 1'b1;
      f = t / (10 * b);
      if (f >= frames.size()) return 1'b1;
      k = (t % (10 * b)) / b;
      if (k == 0) return 1'b0;
      if (k == 9) return 1'b1;
      d = frames[f];
      return d[k-1];
   endfunction

   // Writes burst[0..n-1] on consecutive cycles from idle and checks the
   // line every cycle until the FIFO drains. Bursts are much shorter than a
   // frame, so only the first byte leaves the FIFO during the burst.
   task automatic run_burst(input int b, input int n);
      int t, cnt, total;
      frames.delete();
      for (int i = 0; i < n; i++)
         if (i <= DEPTH) frames.push_back(burst[i]);
      total = frames.size() * 10 * b;
      wr(8'h08, 32'(b));
      wr(8'h00, {24'd0, burst[0]});
      t = -1;
      chk("txd_first_write", {31'd0, txd}, {31'd0, exp_txd(t, b)});
      chk_rd("status_first_write", 8'h04, exp_status(0, 0, 0, 0, 1));
      for (int i = 1; i < n; i++) begin
         wr(8'h00, {24'd0, burst[i]});
         t++;
         cnt = (i < DEPTH) ? i : DEPTH;
         chk("txd_burst", {31'd0, txd}, {31'd0, exp_txd(t, b)});
         chk_rd("status_burst", 8'h04,
                exp_status(1, (cnt == DEPTH) ? 1 : 0, 0, (i > DEPTH) ? 1 : 0, cnt));
      end
      while (t < total - 1) begin
         tick();
         t++;
         if (txd !== exp_txd(t, b))
            chk($sformatf("txd_t%0d", t), {31'd0, txd}, {31'd0, exp_txd(t, b)});
         else
            n_cmp++;
      end
      tick();
      t++;
      chk("txd_after_frames", {31'd0, txd}, 32'd1);
      chk_rd("status_after_frames", 8'h04, exp_status(0, 0, 1, (n > DEPTH + 1) ? 1 : 0, 0));
   endtask

   initial begin
      int b, n, t;
      resetb        = 1'b0;
      io_addr       = '0;
      io_en         = 1'b0;
      io_we         = 1'b0;
      io_data_write = '0;
      tick();
      chk("txd_in_reset", {31'd0, txd}, 32'd1);
      chk_rd("status_in_reset", 8'h04, 32'h4);
      chk_rd("bauddiv_in_reset", 8'h08, BAUD_RST);
      tick();
      resetb = 1'b1;
      tick();

      chk("txd_idle", {31'd0, txd}, 32'd1);
      chk_rd("status_reset", 8'h04, 32'h4);
      chk_rd("bauddiv_reset", 8'h08, BAUD_RST);
      chk_rd("bauddiv_low_bits_ignored", 8'h0B, BAUD_RST);
      chk_rd("txdata_reads_zero", 8'h00, 32'h0);
      chk_rd("irqctl_or_reserved", 8'h0C, 32'h0);
      chk_rd("unmapped_0x10", 8'h10, 32'h0);
      io_addr = 8'h08;
      io_en   = 1'b0;
      #1;
      chk("read_when_not_enabled", io_data_read, 32'h0);
      io_en         = 1'b1;
      io_we         = 1'b1;
      io_data_write = 32'h0;
      io_addr       = 8'h10;
      #1;
      chk("read_during_write", io_data_read, 32'h0);
      io_en = 1'b0;
      io_we = 1'b0;

      wr(8'h08, 32'h0);
      chk_rd("bauddiv_zero_clamped", 8'h08, 32'h2);
      wr(8'h08, 32'h1);
      chk_rd("bauddiv_one_clamped", 8'h08, 32'h2);
      wr(8'h08, 32'hFFFF_1234);
      chk_rd("bauddiv_1234", 8'h08, 32'h0000_1234);
      wr(8'h10, 32'hFFFF_FFFF);
      chk_rd("unmapped_write_ignored", 8'h08, 32'h0000_1234);
      chk_rd("unmapped_still_zero", 8'h10, 32'h0);

      burst[0] = 8'h55;
      run_burst(4, 1);

      for (int i = 0; i < 6; i++) burst[i] = 8'(i + 1);
      run_burst(2, 6);
      wr(8'h04, 32'h7);
      chk_rd("w1c_without_bit3_keeps_ovf", 8'h04, 32'hC);
      wr(8'h04, 32'h8);
      chk_rd("w1c_clears_ovf", 8'h04, 32'h4);

      repeat (8) begin
         b = int'($urandom_range(2, 5));
         n = int'($urandom_range(1, 6));
         for (int i = 0; i < 6; i++) burst[i] = 8'($urandom);
         run_burst(b, n);
         wr(8'h04, 32'h8);
         chk_rd("random_round_clear", 8'h04, 32'h4);
      end

      // Reset in the middle of data bit 3 (bit 3 of 0xF0 is 0, so the line is low).
      frames.delete();
      frames.push_back(8'hF0);
      wr(8'h08, 32'd4);
      wr(8'h00, 32'hF0);
      t = -1;
      while (t < 17) begin
         tick();
         t++;
      end
      chk("txd_before_reset", {31'd0, txd}, {31'd0, exp_txd(t, 4)});
      chk_rd("busy_before_reset", 8'h04, exp_status(1, 0, 1, 0, 0));
      resetb = 1'b0;
      #1;
      chk("txd_at_reset", {31'd0, txd}, 32'd1);
      chk_rd("status_at_reset", 8'h04, 32'h4);
      chk_rd("bauddiv_at_reset", 8'h08, BAUD_RST);
      #2;
      resetb = 1'b1;
      repeat (3) begin
         tick();
         chk("txd_after_reset", {31'd0, txd}, 32'd1);
      end
      chk_rd("status_after_reset", 8'h04, 32'h4);

`ifdef IO_UART_TX_IRQ_EN
      chk("irq_reset", {31'd0, irq}, 32'd0);
      wr(8'h0C, 32'h1);
      chk_rd("irqctl_readback", 8'h0C, 32'h1);
      tick();
      chk("irq_idle_enabled", {31'd0, irq}, 32'd1);
      frames.delete();
      frames.push_back(8'hA3);
      wr(8'h08, 32'd2);
      wr(8'h00, 32'hA3);
      t = -1;
      chk("irq_write_edge", {31'd0, irq}, 32'd1);
      while (t < 21) begin
         tick();
         t++;
         chk($sformatf("irq_t%0d", t), {31'd0, irq}, (t >= 21) ? 32'd1 : 32'd0);
      end
      wr(8'h0C, 32'h0);
      tick();
      chk("irq_disabled", {31'd0, irq}, 32'd0);
      chk_rd("irqctl_cleared", 8'h0C, 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/io_uart_tx.md
IO_UART_TX -- requirements
Module: io_uart_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning TX FIFO entries (power of two).
REQ-002 SHALL have parameter FIFO_DEPTH_LOG, default 2, meaning log2(FIFO_DEPTH).
REQ-003 SHALL have parameter BAUD_DIV_RESET, default 16'd868, meaning reset value of BAUDDIV (clocks per bit).
REQ-004 SHALL have port clk  input  1  system clock; one clock, all state on rising edge.
REQ-005 SHALL have port resetb  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port io_addr  input  8  IO byte address from the MMU IO port.
REQ-007 SHALL have port io_en  input  1  IO access valid this cycle.
REQ-008 SHALL have port io_we  input  1  access is a write when io_en=1.
REQ-009 SHALL have port io_data_write  input  32  write data.
REQ-010 SHALL have port io_data_read  output  32  read data, combinational.
REQ-011 SHALL have port txd  output  1  serial line, idle high.

Function
REQ-012 SHALL decode io_addr[7:2] only; io_addr[1:0] ignored; whole-word access, no byte enables.
REQ-013 Register map SHALL be: 0x00 TXDATA (W), 0x04 STATUS (R/W1C), 0x08 BAUDDIV (R/W, bits[15:0]), 0x0C IRQCTL (see REQ-030); others read 0, writes ignored.
REQ-014 Reads SHALL be zero-latency: io_data_read valid combinationally in the same cycle io_en=1, io_we=0; io_data_read=0 when io_en=0 or io_we=1.
REQ-015 Reads SHALL have no side effects.
REQ-016 Writes SHALL commit on the rising edge ending the cycle with io_en=1, io_we=1.
REQ-017 TXDATA write SHALL push io_data_write[7:0] into the FIFO; TXDATA reads return 0.
REQ-018 STATUS read SHALL return bit0 busy (state!=IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bits[4+FIFO_DEPTH_LOG:4] count, other bits 0.
REQ-019 Push while full with no same-edge pop SHALL drop the byte and set overflow; writing STATUS with bit3=1 SHALL clear overflow; clear-set on same edge: set wins.
REQ-020 Push and pop on the same edge SHALL both occur (count unchanged), including when full.
REQ-021 BAUDDIV write values below 2 SHALL be stored as 2; a new BAUDDIV SHALL take effect at the next bit boundary.
REQ-022 FSM SHALL have states IDLE, START, DATA, STOP; frame 8N1, LSB first, each bit held exactly BAUDDIV clocks.
REQ-023 IDLE: txd=1; when FIFO non-empty, pop head into shift register and enter START on the same edge.
REQ-024 START: txd=0 for one bit period, then DATA with bit index 0.
REQ-025 DATA: txd=shift[0]; after each bit period shift right; after bit index 7 enter STOP.
REQ-026 STOP: txd=1 for one bit period; then pop next byte directly into START if FIFO non-empty (back-to-back, no idle gap), else IDLE.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.

Reset
REQ-028 On resetb low, immediately: txd=1, state IDLE, FIFO empty (count 0), overflow 0, BAUDDIV=BAUD_DIV_RESET, IRQCTL=0, bit counter and divider 0; a frame in progress is abandoned.
REQ-029 io_data_read SHALL remain combinational during reset (value per register contents above).

Configuration
REQ-030 With macro IO_UART_TX_IRQ_EN defined: output port irq (1 bit) SHALL exist; IRQCTL bit0 R/W; irq registered, high when IRQCTL[0]=1 and FIFO empty and state IDLE; reset value 0.
REQ-031 Without IO_UART_TX_IRQ_EN: no irq port; 0x0C reads 0, writes ignored.

Verification
REQ-032 BAUDDIV=4, write TXDATA 0x55 -> txd low 4 clocks, then 1,0,1,0,1,0,1,0 at 4 clocks each, stop high 4 clocks, STATUS busy=0 empty=1.
REQ-033 BAUDDIV=2, 6 back-to-back TXDATA writes 0x01..0x06 while idle -> first pops at once, next 4 fill FIFO (full=1), 6th sets overflow; bytes 0x01..0x05 sent without idle gap; write STATUS 0x8 -> overflow=0.
REQ-034 Write BAUDDIV 0 -> reads back 2; write 0x1234 -> reads back 0x00001234; read 0x10 -> 0.
REQ-035 Assert resetb mid-DATA bit 3 -> txd=1 same cycle, STATUS reads 0x4, BAUDDIV reads 868.
REQ-036 IO_UART_TX_IRQ_EN defined, IRQCTL=1, send one byte -> irq 0 while busy, 1 cycle after return to IDLE with FIFO empty; IRQCTL=0 -> irq 0.
